rob_nway: RTL

ROB_NWAY -- requirements
Module: rob_nway

---
 rtl/rob_nway_pkg.sv | 42 ++++
 rtl/rob_nway_retire_sel.sv | 36 +++
 rtl/rob_nway.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rob_nway_pkg.sv
// Shared system definitions and ROB entry types used by rob_nway and its retire selector.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define SCALAR 1
`define VERILOG_CLOCK_PERIOD 10.0
`define ROB_DEPTH 16
`define ROB_WIDTH 2
`define ROB_IDX 4
`define PRF_IDX 6
`define ARF_IDX 5
`endif

package rob_nway_pkg;

  localparam int PRF_W = `PRF_IDX;
  localparam int ARF_W = `ARF_IDX;

  typedef struct packed {
    logic [63:0] npc;
    logic        isbr;
    logic        bt_pd;
    logic [63:0] ba_pd;
    logic        bt_ex;
    logic [63:0] ba_ex;
  } br_info_t;

  typedef struct packed {
    logic [PRF_W-1:0] pdest;
    logic [ARF_W-1:0] adest;
    br_info_t         br;
  } rob_entry_t;

  // A taken branch is also wrong if it resolved to a different target.
  function automatic logic is_mispredict(input br_info_t b);
    return b.isbr && ((b.bt_ex != b.bt_pd) || (b.bt_ex && (b.ba_ex != b.ba_pd)));
  endfunction

  function automatic logic [63:0] redirect_pc(input br_info_t b);
    return b.bt_ex ? b.ba_ex : b.npc;
  endfunction

endpackage

// File: rtl/rob_nway_retire_sel.sv
// Retire selector: ready-prefix from head, cut after the oldest mispredicting branch.
module rob_retire_sel
  import rob_nway_pkg::*;
#(
  parameter int WIDTH = `ROB_WIDTH
)(
  input  logic [WIDTH-1:0]            i_occ,
  input  logic [WIDTH-1:0]            i_rdy,
  input  br_info_t [WIDTH-1:0]        i_br,
  output logic [WIDTH-1:0]            o_ret,
  output logic                        o_miss,
  output logic [63:0]                 o_target
);

  logic w_run;

  always_comb begin
    o_ret    = '0;
    o_miss   = 1'b0;
    o_target = '0;
    w_run    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_run && i_occ[i] && i_rdy[i]) begin
        o_ret[i] = 1'b1;
        if (is_mispredict(i_br[i])) begin
          o_miss   = 1'b1;
          o_target = redirect_pc(i_br[i]);
          w_run    = 1'b0;
        end
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: contiguous multi-lane dispatch, out-of-order completion, in-order retire.
module rob_nway
  import rob_nway_pkg::*;
#(
  parameter  int DEPTH = `ROB_DEPTH,
  parameter  int WIDTH = `ROB_WIDTH,
  localparam int IW    = $clog2(DEPTH)
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            din_req,
  input  logic [WIDTH-1:0][63:0]      npc_in,
  input  logic [WIDTH-1:0][PRF_W-1:0] pdest_in,
  input  logic [WIDTH-1:0][ARF_W-1:0] adest_in,
  input  logic [WIDTH-1:0]            isbranch_in,
  input  logic [WIDTH-1:0]            bt_pd_in,
  input  logic [WIDTH-1:0][63:0]      ba_pd_in,
  output logic [WIDTH-1:0][IW-1:0]    alloc_idx,
  input  logic [WIDTH-1:0]            dup_req,
  input  logic [WIDTH-1:0][IW-1:0]    rob_idx_in,
  input  logic [WIDTH-1:0]            bt_ex_in,
  input  logic [WIDTH-1:0][63:0]      ba_ex_in,
  output logic [WIDTH-1:0]            dout_valid,
  output logic [WIDTH-1:0][PRF_W-1:0] pdest_out,
  output logic [WIDTH-1:0][ARF_W-1:0] adest_out,
  output logic [WIDTH-1:0][63:0]      npc_out,
  output logic                        branch_miss,
  output logic [63:0]                 correct_target,
  output logic                        full,
  output logic                        full_almost,
  output logic [IW:0]                 free_cnt
);

  rob_entry_t [DEPTH-1:0] r_ent;
  logic [DEPTH-1:0]       r_rdy;
  logic [IW-1:0]          r_head;
  logic [IW-1:0]          r_tail;
  logic [IW:0]            r_count;

  rob_entry_t [DEPTH-1:0] w_ent_nxt;
  logic [DEPTH-1:0]       w_rdy_nxt;
  logic [DEPTH-1:0]       w_slot_occ;
  logic [IW:0]            w_free;
  logic [IW:0]            w_nreq;
  logic [IW:0]            w_nacc;
  logic [IW:0]            w_nret;
  logic [IW-1:0]          w_head_new;
  logic [WIDTH-1:0]       w_hocc;
  logic [WIDTH-1:0]       w_hrdy;
  br_info_t [WIDTH-1:0]   w_hbr;

  assign w_free      = (IW+1)'(DEPTH) - r_count;
  assign free_cnt    = w_free;
  assign full        = (r_count == (IW+1)'(DEPTH));
  assign full_almost = (w_free < (IW+1)'(WIDTH));

  // Occupancy is the distance from head, so slots stay correct across wrap.
  always_comb begin
    for (int s = 0; s < DEPTH; s++)
      w_slot_occ[s] = ({1'b0, IW'(s) - r_head} < r_count);
  end

  always_comb begin
    w_nreq = '0;
    for (int i = 0; i < WIDTH; i++)
      if (din_req[i] && (w_nreq == (IW+1)'(i)))
        w_nreq = w_nreq + 1'b1;
  end

  assign w_nacc = (!branch_miss && (w_nreq <= w_free)) ? w_nreq : '0;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      alloc_idx[i] = r_tail + IW'(i);
      w_hocc[i]    = ((IW+1)'(i) < r_count);
      w_hrdy[i]    = r_rdy[r_head + IW'(i)];
      w_hbr[i]     = r_ent[r_head + IW'(i)].br;
      pdest_out[i] = r_ent[r_head + IW'(i)].pdest;
      adest_out[i] = r_ent[r_head + IW'(i)].adest;
      npc_out[i]   = r_ent[r_head + IW'(i)].br.npc;
    end
  end

  rob_retire_sel #(.WIDTH(WIDTH)) u_sel (
    .i_occ    (w_hocc),
    .i_rdy    (w_hrdy),
    .i_br     (w_hbr),
    .o_ret    (dout_valid),
    .o_miss   (branch_miss),
    .o_target (correct_target)
  );

  always_comb begin
    w_nret = '0;
    for (int i = 0; i < WIDTH; i++)
      w_nret = w_nret + (IW+1)'(dout_valid[i]);
  end

  assign w_head_new = r_head + w_nret[IW-1:0];

  // Later lanes overwrite earlier ones, so the highest duplicate completion wins.
  always_comb begin
    w_ent_nxt = r_ent;
    w_rdy_nxt = r_rdy;
    for (int i = 0; i < WIDTH; i++) begin
      if (dup_req[i] && w_slot_occ[rob_idx_in[i]]) begin
        w_rdy_nxt[rob_idx_in[i]]          = 1'b1;
        w_ent_nxt[rob_idx_in[i]].br.bt_ex = bt_ex_in[i];
        w_ent_nxt[rob_idx_in[i]].br.ba_ex = ba_ex_in[i];
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if ((IW+1)'(i) < w_nacc) begin
        w_rdy_nxt[alloc_idx[i]] = 1'b0;
        w_ent_nxt[alloc_idx[i]] = '{pdest: pdest_in[i], adest: adest_in[i],
                                    br: '{npc: npc_in[i], isbr: isbranch_in[i],
                                          bt_pd: bt_pd_in[i], ba_pd: ba_pd_in[i],
                                          bt_ex: 1'b0, ba_ex: 64'd0}};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rdy   <= '0;
    end else begin
      r_head <= w_head_new;
      if (branch_miss) begin
        r_tail  <= w_head_new;
        r_count <= '0;
        r_rdy   <= '0;
      end else begin
        r_tail  <= r_tail + w_nacc[IW-1:0];
        r_count <= r_count + w_nacc - w_nret;
        r_rdy   <= w_rdy_nxt;
      end
    end
  end

  // Payload storage carries no reset; occupancy and rdy gate its use.
  always_ff @(posedge clk) begin
    if (!branch_miss)
      r_ent <= w_ent_nxt;
  end

endmodule
